// File: rtl/cap_pkg.sv
// Shared defaults and width helpers for the event-capture counter and its FIFO.
package cap_pkg;

  localparam int CAP_WIDTH = 32;
  localparam int CAP_DEPTH = 4;
  localparam int CAP_PTR_W = $clog2(CAP_DEPTH);
  localparam int CAP_LVL_W = CAP_PTR_W + 1;

  // Per-cycle FIFO operation decode; drop marks a capture lost to a full FIFO.
  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
  } fifo_op_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cap_fifo.sv
// Show-ahead capture FIFO: a push is visible on rdata one cycle later, pops update next cycle.
// A push into a full FIFO without a same-cycle pop is dropped and sets the sticky ovf flag.
module cap_fifo
  import cap_pkg::*;
#(
  parameter int WIDTH = CAP_WIDTH,
  parameter int DEPTH = CAP_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_dat,
  input  logic                      rd,
  output logic [WIDTH-1:0]          rdata,
  output logic                      valid,
  output logic [ptr_w(DEPTH):0]     level,
  output logic                      ovf
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    lvl_q;
  logic             ovf_q;
  logic             full;
  fifo_op_t         op;

  assign full = (lvl_q == LW'(DEPTH));

  // A pop frees the head slot, so a simultaneous push into a full FIFO still lands.
  always_comb begin
    op      = '0;
    op.pop  = rd & (lvl_q != '0) & ~clr;
    op.push = push & ~clr & (~full | op.pop);
    op.drop = push & ~clr & full & ~op.pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (op.push) wr_ptr <= wr_ptr + PW'(1);
      if (op.pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({op.push, op.pop})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: lvl_q <= lvl_q;
      endcase
      if (op.drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (op.push) mem[wr_ptr] <= push_dat;
  end

  assign valid = (lvl_q != '0);
  assign rdata = valid ? mem[rd_ptr] : '0;
  assign level = lvl_q;
  assign ovf   = ovf_q;

  a_level_range: assert property (@(posedge clk) disable iff (!rst_n) lvl_q <= LW'(DEPTH));

endmodule

// File: rtl/counter_capture_32.sv
// Free-running counter with RC wrap pulse; evt rising edges push the pre-increment count into cap_fifo.
// Capture-to-rdata latency 1; full FIFO drops captures (ovf). CAPTURE_DELTA_EN pushes the delta since the last rise.
module counter_capture_32
  import cap_pkg::*;
#(
  parameter int WIDTH = CAP_WIDTH,
  parameter int DEPTH = CAP_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      evt,
  input  logic                      rd,
  output logic [WIDTH-1:0]          cnt,
  output logic                      RC,
  output logic [WIDTH-1:0]          rdata,
  output logic                      valid,
  output logic [ptr_w(DEPTH):0]     level,
  output logic                      ovf
);

  logic [WIDTH-1:0] cnt_q;
  logic             rc_q;
  logic             evt_d;
  logic             rise;
  logic             push;
  logic [WIDTH-1:0] push_dat;

  assign rise = evt & ~evt_d;
  assign push = rise & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rc_q  <= 1'b0;
      evt_d <= 1'b0;
    end else begin
      evt_d <= evt;
      if (clr) begin
        cnt_q <= '0;
        rc_q  <= 1'b0;
      end else begin
        rc_q <= en & (&cnt_q);
        if (en) cnt_q <= cnt_q + WIDTH'(1);
      end
    end
  end

`ifdef CAPTURE_DELTA_EN
  logic [WIDTH-1:0] base_q;

  // Base follows every detected rise, even one the FIFO drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
    end else if (clr) begin
      base_q <= '0;
    end else if (rise) begin
      base_q <= cnt_q;
    end
  end

  assign push_dat = cnt_q - base_q;
`else
  assign push_dat = cnt_q;
`endif

  cap_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (push),
    .push_dat (push_dat),
    .rd       (rd),
    .rdata    (rdata),
    .valid    (valid),
    .level    (level),
    .ovf      (ovf)
  );

  assign cnt = cnt_q;
  assign RC  = rc_q;

endmodule

// File: tb/tb_counter_capture_32.sv
module tb_counter_capture_32;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, clr, evt, rd;
  logic [W-1:0]  cnt, rdata;
  logic          rc, valid, ovf;
  logic [2:0]    level;

  logic          en8, clr8, zero8;
  logic [7:0]    cnt8, rdata8;
  logic          rc8, valid8, ovf8;
  logic [2:0]    level8;

  int n_chk = 0;
  int n_bad = 0;

  counter_capture_32 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .evt(evt), .rd(rd),
    .cnt(cnt), .RC(rc), .rdata(rdata), .valid(valid), .level(level), .ovf(ovf)
  );

  counter_capture_32 #(.WIDTH(8), .DEPTH(D)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .clr(clr8), .evt(zero8), .rd(zero8),
    .cnt(cnt8), .RC(rc8), .rdata(rdata8), .valid(valid8), .level(level8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  // Reference model: counter as an integer, FIFO as a queue.
  logic [W-1:0] m_cnt;
  logic         m_rc;
  logic         m_ovf;
  logic [W-1:0] m_base;
  logic         m_prev;
  logic [W-1:0] m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_rc = 1'b0; m_ovf = 1'b0; m_base = '0; m_prev = 1'b0;
    m_q.delete();
  endtask

  task automatic model_cycle(input logic e, input logic c, input logic v, input logic r);
    logic [W-1:0] val;
    if (c) begin
      m_cnt = '0; m_rc = 1'b0; m_ovf = 1'b0; m_base = '0;
      m_q.delete();
    end else begin
      if (r && m_q.size() > 0) void'(m_q.pop_front());
      if (v && !m_prev) begin
`ifdef CAPTURE_DELTA_EN
        val = m_cnt - m_base;
        m_base = m_cnt;
`else
        val = m_cnt;
`endif
        if (m_q.size() < D) m_q.push_back(val);
        else m_ovf = 1'b1;
      end
      m_rc = e && (m_cnt == {W{1'b1}});
      if (e) m_cnt = m_cnt + 1;
    end
    m_prev = v;
  endtask

  task automatic check_all();
    chk("cnt", cnt, m_cnt);
    chk("rc", rc, m_rc);
    chk("valid", valid, m_q.size() != 0);
    chk("level", level, m_q.size());
    chk("ovf", ovf, m_ovf);
    chk("rdata", rdata, (m_q.size() != 0) ? m_q[0] : '0);
  endtask

  task automatic step(input logic e, input logic c, input logic v, input logic r);
    en = e; clr = c; evt = v; rd = r;
    @(posedge clk);
    model_cycle(e, c, v, r);
    #1 check_all();
  endtask

  task automatic rise_at(input logic [W-1:0] target);
    for (int k = 0; k < 600 && m_cnt != target; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reach_cnt", cnt, target);
    step(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pop_chk(input string tag, input logic [W-1:0] exp);
    chk(tag, rdata, exp);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] e36 [3];
    logic [W-1:0] e39 [3];
`ifdef CAPTURE_DELTA_EN
    e36[0] = 10;  e36[1] = 15;  e36[2] = 15;
    e39[0] = 100; e39[1] = 50;  e39[2] = 80;
`else
    e36[0] = 10;  e36[1] = 25;  e36[2] = 40;
    e39[0] = 100; e39[1] = 150; e39[2] = 230;
`endif
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; evt = 1'b0; rd = 1'b0;
    en8 = 1'b0; clr8 = 1'b0; zero8 = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("w8_cnt_rst", cnt8, 0);
    @(negedge clk) rst_n = 1'b1;

    // Five enabled cycles from reset
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("cnt_after5", cnt, 5);
    chk("rc_after5", rc, 0);
    chk("valid_after5", valid, 0);

    // Three captures, then drain in order
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rise_at(10); rise_at(25); rise_at(40);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("level_3", level, 3);
    pop_chk("pop0", e36[0]);
    pop_chk("pop1", e36[1]);
    pop_chk("pop2", e36[2]);
    chk("valid_drained", valid, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rd_empty_level", level, 0);

    // Overflow: five captures into four slots, then clr
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rise_at(10); rise_at(20); rise_at(30); rise_at(40); rise_at(50);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_level", level, 4);
    chk("ovf_set", ovf, 1);
    chk("ovf_head", rdata, 10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr_ovf", ovf, 0);
    chk("clr_level", level, 0);

    // Full FIFO with simultaneous capture and pop
    rise_at(10); rise_at(20); rise_at(30); rise_at(40);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_level", level, 4);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("full_pushpop_level", level, 4);
    chk("full_pushpop_ovf", ovf, 0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Capture sequence 100/150/230
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rise_at(100); rise_at(150); rise_at(230);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    pop_chk("p100", e39[0]);
    pop_chk("p150", e39[1]);
    pop_chk("p230", e39[2]);

    // Asynchronous reset in mid-stream
    rise_at(240); rise_at(250);
    #2 rst_n = 1'b0; en = 1'b0; evt = 1'b0; rd = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("arst_cnt", cnt, 0);
    chk("arst_level", level, 0);
    chk("arst_rdata", rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_level", level, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);

    // Counter wrap and RC pulse on the 8-bit instance
    @(negedge clk) clr8 = 1'b1;
    @(posedge clk); #1;
    clr8 = 1'b0; en8 = 1'b1;
    repeat (254) @(posedge clk);
    #1 chk("w8_fe", cnt8, 8'hFE);
    chk("w8_rc_fe", rc8, 0);
    @(posedge clk); #1;
    chk("w8_ff", cnt8, 8'hFF);
    chk("w8_rc_ff", rc8, 0);
    @(posedge clk); #1;
    chk("w8_wrap", cnt8, 8'h00);
    chk("w8_rc_pulse", rc8, 1);
    en8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_rc_drop", rc8, 0);
    chk("w8_hold", cnt8, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_capture_32.md
COUNTER_CAPTURE_32 -- requirements
Module: counter_capture_32

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the counter and capture data width.
REQ-002 Parameter DEPTH, default 4 (power of two), SHALL set the capture FIFO entry count.
REQ-003 clk  input  1  SHALL be the single clock; all logic SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL enable counter increment.
REQ-006 clr  input  1  SHALL synchronously clear the counter, FIFO, ovf and the delta base.
REQ-007 evt  input  1  SHALL be the event line, synchronous to clk; its rising edges are captured.
REQ-008 rd  input  1  SHALL pop the FIFO head.
REQ-009 cnt  output  WIDTH  SHALL present the live counter value.
REQ-010 RC  output  1  SHALL pulse for one cycle on counter wrap.
REQ-011 rdata  output  WIDTH  SHALL present the FIFO head (show-ahead).
REQ-012 valid  output  1  SHALL be high when the FIFO holds at least one entry.
REQ-013 level  output  log2(DEPTH)+1  SHALL present the current FIFO occupancy.
REQ-014 ovf  output  1  SHALL be a sticky flag marking a dropped capture.

Function
REQ-015 Counter: en=1 and clr=0 SHALL give cnt <= cnt+1 modulo 2^WIDTH; en=0 SHALL hold cnt.
REQ-016 RC SHALL be registered high in the cycle after an increment from all-ones to 0, and low otherwise.
REQ-017 clr SHALL take priority over en: cnt <= 0, RC <= 0, FIFO emptied, ovf <= 0, delta base <= 0.
REQ-018 Edge detect: evt SHALL be registered into evt_d; rise = evt & ~evt_d.
REQ-019 On rise, the value captured SHALL be the cnt value present in that same cycle, before that cycle's increment.
REQ-020 Pushing into an empty FIFO SHALL assert valid, with rdata set to the captured value, in the next cycle (latency 1).
REQ-021 rd with valid=1 SHALL pop one entry; rdata/level SHALL update in the next cycle.
REQ-022 rd with valid=0 SHALL be ignored with no state change.
REQ-023 Push with pop in the same cycle SHALL leave level unchanged, including when the FIFO is full; ovf SHALL not be set.
REQ-024 Push while full without pop SHALL drop the capture, leave FIFO contents intact, and set ovf=1.
REQ-025 ovf SHALL hold until clr or reset.
REQ-026 Pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-027 rise and clr in the same cycle: clr SHALL win and the capture SHALL be discarded.

Reset
REQ-028 While rst_n=0, the block SHALL force cnt=0, RC=0, valid=0, level=0, ovf=0, rdata=0, evt_d=0, pointers=0 and delta base=0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents; no capture SHALL occur in the first cycle after release unless a rise is detected.

Configuration
REQ-030 Macro CAPTURE_DELTA_EN defined: the pushed value SHALL be (cnt - base) mod 2^WIDTH, and base <= cnt on every detected rise, including dropped ones.
REQ-031 Macro CAPTURE_DELTA_EN undefined: the raw cnt SHALL be pushed and no base register SHALL exist.

Structure
REQ-032 Package cap_pkg SHALL hold the WIDTH/DEPTH defaults, the pointer-width constant (log2 DEPTH) and the level-width constant.
REQ-033 The FIFO (storage, pointers, level, ovf logic) SHALL be one sub-module, cap_fifo; the counter, edge detect and delta logic SHALL stay in the top level.

Verification
REQ-034 Reset, en=1 for 5 cycles -> cnt=5, RC=0, valid=0.
REQ-035 Load cnt to 0xFFFFFFFE via clr + forced count, en=1 for 2 cycles -> cnt=0x00000000 and RC high for exactly one cycle.
REQ-036 Rises at cnt=10, 25, 40 with no rd -> level=3, then rdata=10, 25, 40 in pop order; valid=0 after the third pop.
REQ-037 5 rises with no rd (DEPTH=4) -> level=4, ovf=1, first four values retained; clr -> ovf=0, level=0.
REQ-038 FIFO full, rise and rd in the same cycle -> level stays 4, ovf stays 0, new value at tail.
REQ-039 CAPTURE_DELTA_EN defined, rises at cnt=100, 150, 230 -> popped values 100, 50, 80; rst_n pulsed mid-stream -> all outputs 0.
